bird_sprite_renderer: RTL and testbench
=======================================

Name: bird_sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream of the 12x18 bird flap sprite ROMs; downstream of the VGA timing/background stage.
- Maps the current screen pixel onto sprite row/col addresses and selects the animation frame (flap ROM 0..2).
- Aligns the background pixel with the ROMs' 1-cycle registered read, applies key-colour transparency and emits the composited pixel plus a bird-opaque flag for collision logic.

Parameters:
- SPRITE_W, 18, sprite width in pixels (cols 0..17)
- SPRITE_H, 12, sprite height in pixels (rows 0..11)
- KEY_COLOUR, 24'hFF0096, transparent colour in the ROM data
- HOLD_FRAMES, 4, frame_ticks each flap frame is held
- COORD_W, 10, width of screen coordinates

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- pixel_x  in  COORD_W  current screen x
- pixel_y  in  COORD_W  current screen y
- pixel_valid  in  1  pixel_x/y/bg_colour valid this cycle
- bg_colour  in  24  background pixel for pixel_x/y
- bird_x  in  COORD_W  sprite top-left x
- bird_y  in  COORD_W  sprite top-left y
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- flap  in  1  flap request (level or pulse)
- rom_row  out  4  row address to flap ROMs
- rom_col  out  5  col address to flap ROMs
- frame_sel  out  2  selects flap ROM 0/1/2 (value 3 never driven)
- rom_colour  in  24  muxed ROM colour_data, valid 1 cycle after rom_row/rom_col
- pix_colour  out  24  composited pixel
- pix_valid  out  1  pix_colour valid
- bird_opaque  out  1  pix_colour came from a non-key sprite pixel

Behaviour:
- Address stage (combinational): dx = pixel_x - bird_x, dy = pixel_y - bird_y, COORD_W+1 bits signed; in_box = dx,dy >= 0 and dx < SPRITE_W and dy < SPRITE_H. rom_col = dx[4:0], rom_row = dy[3:0] when in_box, else 0.
- Stage 1 registers (aligned with ROM read): in_box_d, bg_d, valid_d <= pixel_valid.
- Stage 2 registers: pix_valid <= valid_d; if valid_d and in_box_d and rom_colour != KEY_COLOUR then pix_colour <= rom_colour, bird_opaque <= 1; else pix_colour <= bg_d, bird_opaque <= 0.
- Latency pixel_valid -> pix_valid: exactly 2 cycles, fully pipelined, one pixel per cycle. No backpressure.
- When valid_d = 0: pix_valid = 0, pix_colour and bird_opaque hold their previous values.
- Animation FSM, states GLIDE, FLAP_A, FLAP_B, FLAP_C. frame_sel: GLIDE=0, FLAP_A=1, FLAP_B=2, FLAP_C=1.
- flap_pending is set by flap = 1 on any cycle and cleared on frame_tick.
- State and frame_sel change only on frame_tick, so there is no mid-frame tearing.
- On frame_tick, if flap_pending or flap is set: go to FLAP_A and clear hold_cnt (restarts the animation from any state).
- Otherwise, in a FLAP state: hold_cnt increments. When hold_cnt = HOLD_FRAMES-1, hold_cnt clears and the FSM advances A->B->C->GLIDE.
- GLIDE with no flap: stays in GLIDE.
- Reset values: state GLIDE, frame_sel 0, hold_cnt 0, flap_pending 0, pix_valid 0, pix_colour 0, bird_opaque 0, all pipeline registers 0.
- Reset asserted mid-operation clears everything immediately. The first pix_valid after reset release comes no earlier than 2 cycles after the first pixel_valid.
- Boundaries:
  - bird partly off-screen (bird_x > pixel range): the signed compare keeps in_box correct, no wrap.
  - pixel_x = bird_x+17 is inside the box; bird_x+18 is outside.

Optional Feature:
- SPRITE_SCALE2X_EN defined: box becomes 2*SPRITE_W x 2*SPRITE_H (36x24); rom_col = dx>>1, rom_row = dy>>1. Latency is unchanged.
- Undefined: 1:1 mapping as above.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> pix_valid=0, pix_colour=0, frame_sel=0 within the same cycle; release -> first pix_valid exactly 2 cycles after pixel_valid.
- Opaque hit: bird=(100,50), pixel=(106,50), rom_colour=24'h533846 one cycle later -> rom_row=0, rom_col=6; 2 cycles later pix_colour=24'h533846, bird_opaque=1.
- Transparency: same position, rom_colour=24'hFF0096, bg=24'h4EC0CA -> pix_colour=24'h4EC0CA, bird_opaque=0.
- Box edges: bird=(100,50); pixel (117,61) -> in box, row 11, col 17; (118,61) and (99,50) -> bg passed through, rom_row/col=0.
- Animation: flap pulse, then 13 frame_ticks with HOLD_FRAMES=4 -> frame_sel 1 after tick 1; 2 after tick 5; 1 after tick 9; 0 after tick 13. Re-flap during FLAP_B -> frame_sel=1 on next tick.
- Streaming: 640 consecutive valid pixels -> 640 consecutive pix_valid, order preserved, 2-cycle offset.

Source files
------------

// File: rtl/bird_sprite_renderer_if.sv
// rtl/bird_sprite_renderer_if.sv - pixel-in / composited-pixel-out bundle for the bird sprite stage
interface bird_sprite_renderer_if #(
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               pixel_valid;
  logic [23:0]        bg_colour;
  logic [23:0]        pix_colour;
  logic               pix_valid;
  logic               bird_opaque;

  modport master (
    output pixel_x, pixel_y, pixel_valid, bg_colour,
    input  pix_colour, pix_valid, bird_opaque
  );

  modport slave (
    input  pixel_x, pixel_y, pixel_valid, bg_colour,
    output pix_colour, pix_valid, bird_opaque
  );
endinterface

// File: rtl/bird_sprite_renderer.sv
// rtl/bird_sprite_renderer.sv - bird sprite addressing, flap animation and key-colour compositing
// Optional SPRITE_SCALE2X_EN: doubles the sprite box and halves the ROM address step.
module bird_sprite_renderer #(
  parameter int          SPRITE_W    = 18,
  parameter int          SPRITE_H    = 12,
  parameter logic [23:0] KEY_COLOUR  = 24'hFF0096,
  parameter int          HOLD_FRAMES = 4,
  parameter int          COORD_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bird_sprite_renderer_if.slave pix,
  input  logic [COORD_W-1:0]    bird_x,
  input  logic [COORD_W-1:0]    bird_y,
  input  logic                  frame_tick,
  input  logic                  flap,
  output logic [3:0]            rom_row,
  output logic [4:0]            rom_col,
  output logic [1:0]            frame_sel,
  input  logic [23:0]           rom_colour
);

`ifdef SPRITE_SCALE2X_EN
  localparam int BOX_W = 2 * SPRITE_W;
  localparam int BOX_H = 2 * SPRITE_H;
`else
  localparam int BOX_W = SPRITE_W;
  localparam int BOX_H = SPRITE_H;
`endif
  localparam logic signed [COORD_W:0] BOX_W_S = (COORD_W+1)'(BOX_W);
  localparam logic signed [COORD_W:0] BOX_H_S = (COORD_W+1)'(BOX_H);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {GLIDE, FLAP_A, FLAP_B, FLAP_C} state_t;

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic                    in_box;
  logic [4:0]              col_raw;
  logic [3:0]              row_raw;

  // One extra sign bit keeps an off-screen bird from wrapping into the box.
  assign dx = $signed({1'b0, pix.pixel_x}) - $signed({1'b0, bird_x});
  assign dy = $signed({1'b0, pix.pixel_y}) - $signed({1'b0, bird_y});
  assign in_box = !dx[COORD_W] && !dy[COORD_W] && (dx < BOX_W_S) && (dy < BOX_H_S);

`ifdef SPRITE_SCALE2X_EN
  assign col_raw = dx[5:1];
  assign row_raw = dy[4:1];
`else
  assign col_raw = dx[4:0];
  assign row_raw = dy[3:0];
`endif

  assign rom_col = in_box ? col_raw : '0;
  assign rom_row = in_box ? row_raw : '0;

  logic        in_box_d;
  logic        valid_d;
  logic [23:0] bg_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_d        <= 1'b0;
      valid_d         <= 1'b0;
      bg_d            <= '0;
      pix.pix_valid   <= 1'b0;
      pix.pix_colour  <= '0;
      pix.bird_opaque <= 1'b0;
    end else begin
      in_box_d      <= in_box;
      valid_d       <= pix.pixel_valid;
      bg_d          <= pix.bg_colour;
      pix.pix_valid <= valid_d;
      if (valid_d) begin
        if (in_box_d && (rom_colour != KEY_COLOUR)) begin
          pix.pix_colour  <= rom_colour;
          pix.bird_opaque <= 1'b1;
        end else begin
          pix.pix_colour  <= bg_d;
          pix.bird_opaque <= 1'b0;
        end
      end
    end
  end

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            flap_pending;

  // Everything visible changes only on frame_tick so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= GLIDE;
      frame_sel    <= 2'd0;
      hold_cnt     <= '0;
      flap_pending <= 1'b0;
    end else if (frame_tick) begin
      flap_pending <= 1'b0;
      if (flap_pending || flap) begin
        state     <= FLAP_A;
        frame_sel <= 2'd1;
        hold_cnt  <= '0;
      end else if (state != GLIDE) begin
        if (hold_cnt == HOLD_MAX) begin
          hold_cnt <= '0;
          case (state)
            FLAP_A: begin
              state     <= FLAP_B;
              frame_sel <= 2'd2;
            end
            FLAP_B: begin
              state     <= FLAP_C;
              frame_sel <= 2'd1;
            end
            default: begin
              state     <= GLIDE;
              frame_sel <= 2'd0;
            end
          endcase
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end else if (flap) begin
      flap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// tb/tb_bird_sprite_renderer.sv - randomized and directed checks of bird_sprite_renderer against a reference model
module tb_bird_sprite_renderer;
  localparam logic [23:0] KEY = 24'hFF0096;
  localparam int HOLD = 4;
`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  bird_x, bird_y;
  logic        frame_tick, flap;
  logic [3:0]  rom_row;
  logic [4:0]  rom_col;
  logic [1:0]  frame_sel;
  logic [23:0] rom_colour;

  bird_sprite_renderer_if pif ();

  bird_sprite_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix        (pif),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .frame_tick (frame_tick),
    .flap       (flap),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .frame_sel  (frame_sel),
    .rom_colour (rom_colour)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [23:0] c;
    logic        o;
  } exp_t;

  logic [23:0] rom_mem [512];
  exp_t        q[$];
  logic [23:0] held_c;
  logic        held_o;
  int          anim;
  bit          pending;
  logic [1:0]  exp_sel;
  int          tests, errors, vcount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_addr(input int px, input int py, input int bx, input int by,
                                     output bit inb, output int r, output int c);
    int ddx, ddy;
    ddx = px - bx;
    ddy = py - by;
    inb = (ddx >= 0) && (ddx < 18 * SC) && (ddy >= 0) && (ddy < 12 * SC);
    r = inb ? ddy / SC : 0;
    c = inb ? ddx / SC : 0;
  endfunction

  // Called on a falling edge; returns on the next falling edge.
  task automatic cycle(input bit pv, input int px, input int py, input logic [23:0] bg,
                       input int bx, input int by, input bit tk, input bit fl);
    exp_t        e;
    bit          inb;
    int          r, c;
    logic [23:0] rv;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("pix_valid", pif.pix_valid, e.v);
      check("pix_colour", pif.pix_colour, e.c);
      check("bird_opaque", pif.bird_opaque, e.o);
      if (pif.pix_valid) vcount++;
    end else begin
      check("pix_valid_early", pif.pix_valid, 0);
    end
    check("frame_sel", frame_sel, exp_sel);
    rom_colour = rom_mem[{rom_row, rom_col}];
    pif.pixel_valid = pv;
    pif.pixel_x     = 10'(px);
    pif.pixel_y     = 10'(py);
    pif.bg_colour   = bg;
    bird_x          = 10'(bx);
    bird_y          = 10'(by);
    frame_tick      = tk;
    flap            = fl;
    if (tk) begin
      if (pending || fl) anim = 0;
      else if (anim >= 0) begin
        anim++;
        if (anim >= 3 * HOLD) anim = -1;
      end
      pending = 0;
    end else if (fl) begin
      pending = 1;
    end
    exp_sel = (anim < 0) ? 2'd0 : ((anim / HOLD) == 1 ? 2'd2 : 2'd1);
    model_addr(px, py, bx, by, inb, r, c);
    rv = rom_mem[r * 32 + c];
    if (pv) begin
      held_o = inb && (rv != KEY);
      held_c = held_o ? rv : bg;
    end
    e.v = pv;
    e.c = held_c;
    e.o = held_o;
    q.push_back(e);
    #1;
    check("rom_row", rom_row, r);
    check("rom_col", rom_col, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_pix_valid", pif.pix_valid, 0);
    check("rst_pix_colour", pif.pix_colour, 0);
    check("rst_bird_opaque", pif.bird_opaque, 0);
    check("rst_frame_sel", frame_sel, 0);
    q.delete();
    held_c = '0;
    held_o = 1'b0;
    anim = -1;
    pending = 0;
    exp_sel = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int wrap(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  initial begin
    int sel_tab[13];
    int bx, by, off;
    sel_tab = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 0};
    tests = 0; errors = 0; vcount = 0;
    for (int i = 0; i < 512; i++)
      rom_mem[i] = ($urandom_range(3) == 0) ? KEY : 24'($urandom);
    rom_mem[6] = 24'h533846;
    reset_n = 1'b1;
    pif.pixel_valid = 0; pif.pixel_x = 0; pif.pixel_y = 0; pif.bg_colour = 0;
    bird_x = 0; bird_y = 0; frame_tick = 0; flap = 0; rom_colour = 0;
    #2;
    do_reset();

    // Opaque hit and transparency at (106,50) with bird at (100,50)
    cycle(1, 106, 50, 24'h4EC0CA, 100, 50, 0, 0);
    check("hit_row", rom_row, 0);
    check("hit_col", rom_col, 6);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    check("hit_colour", pif.pix_colour, 24'h533846);
    check("hit_opaque", pif.bird_opaque, 1);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    rom_mem[6] = KEY;
    cycle(1, 106, 50, 24'h4EC0CA, 100, 50, 0, 0);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    check("key_colour", pif.pix_colour, 24'h4EC0CA);
    check("key_opaque", pif.bird_opaque, 0);

    // Box edges and an off-screen bird
    cycle(1, 117, 61, 24'h111111, 100, 50, 0, 0);
    check("edge_in_row", rom_row, 11);
    check("edge_in_col", rom_col, 17);
    cycle(1, 118, 61, 24'h222222, 100, 50, 0, 0);
    check("edge_out_col", rom_col, 0);
    cycle(1, 99, 50, 24'h333333, 100, 50, 0, 0);
    check("edge_left_col", rom_col, 0);
    cycle(1, 1020, 5, 24'h444444, 1015, 3, 0, 0);
    cycle(1, 2, 5, 24'h555555, 1015, 3, 0, 0);
    check("wrap_col", rom_col, 0);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);

    // Animation sequence, then a re-flap during FLAP_B
    cycle(0, 0, 0, 0, 100, 50, 0, 1);
    for (int t = 0; t < 13; t++) begin
      cycle(0, 0, 0, 0, 100, 50, 0, 0);
      cycle(0, 0, 0, 0, 100, 50, 1, 0);
      cycle(0, 0, 0, 0, 100, 50, 0, 0);
      check("anim_sel", frame_sel, sel_tab[t]);
    end
    cycle(0, 0, 0, 0, 100, 50, 0, 1);
    for (int t = 0; t < 5; t++) cycle(0, 0, 0, 0, 100, 50, 1, 0);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    check("anim_flap_b", frame_sel, 2);
    cycle(0, 0, 0, 0, 100, 50, 0, 1);
    cycle(0, 0, 0, 0, 100, 50, 1, 0);
    cycle(0, 0, 0, 0, 100, 50, 0, 0);
    check("anim_reflap", frame_sel, 1);

    // 640-pixel line of back-to-back valid pixels
    cycle(0, 0, 0, 0, 300, 40, 0, 0);
    cycle(0, 0, 0, 0, 300, 40, 0, 0);
    vcount = 0;
    for (int i = 0; i < 640; i++)
      cycle(1, i, 40 + (i % 12), 24'($urandom), 300, 40, 0, 0);
    cycle(0, 0, 0, 0, 300, 40, 0, 0);
    cycle(0, 0, 0, 0, 300, 40, 0, 0);
    check("stream_count", vcount, 640);

    // Randomized traffic with a mid-stream reset
    bx = 200; by = 100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        bx = $urandom_range(1023);
        by = $urandom_range(1023);
      end
      if (i == 1500) do_reset();
      off = int'($urandom_range(24)) - 3;
      cycle($urandom_range(4) != 0, wrap(bx + off), wrap(by + int'($urandom_range(15)) - 2),
            24'($urandom), bx, by, $urandom_range(29) == 0, $urandom_range(49) == 0);
    end
    cycle(0, 0, 0, 0, bx, by, 0, 0);
    cycle(0, 0, 0, 0, bx, by, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
